// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter between the CPU
// control unit and the debug/loader port.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_W       = 3;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DBG_RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of IDLE cycles in which a pending debug request was denied;
// cleared whenever the debug port is granted.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [WAIT_W-1:0] wait_cnt
);

    localparam logic [WAIT_W-1:0] SAT = WAIT_W'(MAX_WAIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt < SAT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the CPU control unit
// and a debug/loader port, forcing debug through after MAX_WAIT denied cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    input  logic              dbg_halt,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output arb_state_t        arb_state,
    output logic [WAIT_W-1:0] wait_cnt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    // Debug handshake: dbg_req is a level held by the requester until it sees
    // dbg_ack; the grant cycle N presents the access to memory, dbg_ack pulses
    // for exactly cycle N+1 (with read data), and a request still high in the
    // following IDLE cycle is a fresh request.
    arb_state_t state, state_nxt;
    logic       cpu_req;
    logic       dbg_grant;
    logic       cpu_own;
    logic       wait_inc;

    assign cpu_req   = cpu_rd | cpu_wr;
    assign arb_state = state;

    mem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clock    (clock),
        .reset    (reset),
        .inc      (wait_inc),
        .clr      (dbg_grant),
        .wait_cnt (wait_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // All outputs are gated by reset so they read 0 while it is asserted,
    // without waiting for a clock edge.
    always_comb begin
        state_nxt = state;
        dbg_grant = 1'b0;
        wait_inc  = 1'b0;
        cpu_own   = 1'b0;
        cpu_stall = 1'b0;
        dbg_ack   = 1'b0;
        dbg_rdata = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    dbg_grant = dbg_req &&
                                (!cpu_req || dbg_halt || (wait_cnt == MAX_WAIT_C));
                    wait_inc  = dbg_req && !dbg_grant;
                    if (dbg_grant) begin
                        state_nxt = ST_DBG_RESP;
                    end
                end
                ST_DBG_RESP: begin
                    dbg_ack   = 1'b1;
                    dbg_rdata = mem_rdata;
                    state_nxt = ST_IDLE;
                end
            endcase

            cpu_own = cpu_req && !dbg_halt && !dbg_grant;

            if (dbg_grant) begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_we    = dbg_we;
            end else if (cpu_own) begin
                // A simultaneous read+write performs the write only.
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_wr;
            end

            cpu_stall = cpu_req && !cpu_own;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter MAX_WAIT, default 4, number of cycles a debug request may be denied before it is forced (range 1..7).
REQ-004 Port `clock`, in, 1: single clock; all state changes on its rising edge.
REQ-005 Port `reset`, in, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port `cpu_rd`, in, 1: processor control unit requests a memory read this cycle.
REQ-007 Port `cpu_wr`, in, 1: processor control unit requests a memory write this cycle.
REQ-008 Port `cpu_addr`, in, ADDR_W: processor address.
REQ-009 Port `cpu_wdata`, in, DATA_W: processor write data.
REQ-010 Port `cpu_stall`, out, 1: processor access not performed this cycle; the control unit holds its state.
REQ-011 Port `dbg_halt`, in, 1: level; while 1, the processor is denied the port.
REQ-012 Port `dbg_req`, in, 1: level; debug/loader request, held until `dbg_ack`.
REQ-013 Port `dbg_we`, in, 1: debug request is a write.
REQ-014 Port `dbg_addr`, in, ADDR_W: debug address.
REQ-015 Port `dbg_wdata`, in, DATA_W: debug write data.
REQ-016 Port `dbg_ack`, out, 1: one-cycle completion pulse.
REQ-017 Port `dbg_rdata`, out, DATA_W: read data, valid only while `dbg_ack`=1 and the request was a read.
REQ-018 Port `mem_addr`, out, ADDR_W: address to the single-port synchronous memory.
REQ-019 Port `mem_wdata`, out, DATA_W: write data to the memory.
REQ-020 Port `mem_we`, out, 1: memory write enable.
REQ-021 Port `mem_rdata`, in, DATA_W: memory read data, valid one cycle after the address is presented.

Function
REQ-022 The arbiter SHALL have two states: IDLE and DBG_RESP.
REQ-023 In IDLE, the debug port SHALL be granted when `dbg_req`=1 and any of the following holds: the CPU is not requesting (`cpu_rd`=`cpu_wr`=0); `dbg_halt`=1; or `wait_cnt`=MAX_WAIT.
REQ-024 In IDLE without a debug grant, the CPU SHALL own the port.
REQ-025 The port owner SHALL drive `mem_addr`, `mem_wdata` and `mem_we` combinationally in the same cycle.
REQ-026 A CPU access SHALL drive `mem_we`=`cpu_wr`; if `cpu_rd` and `cpu_wr` are both 1, the write SHALL be performed and the read ignored.
REQ-027 `cpu_stall`=1 SHALL be driven whenever (`cpu_rd`|`cpu_wr`)=1 and the CPU does not own the port, including every cycle in which `dbg_halt`=1.
REQ-028 On a debug grant in IDLE, the next state SHALL be DBG_RESP.
REQ-029 In DBG_RESP: `dbg_ack`=1; `dbg_rdata`=`mem_rdata`; `dbg_req` is ignored; the CPU may own the port (subject to `dbg_halt`); next state IDLE.
REQ-030 Debug latency SHALL be: grant cycle N, ack in cycle N+1; a debug write is committed in cycle N.
REQ-031 `dbg_req` still high in IDLE after an ack SHALL be treated as a new request.
REQ-032 `wait_cnt` (3 bits) SHALL increment, saturating at MAX_WAIT, on each IDLE cycle with `dbg_req`=1 and no debug grant, and SHALL clear on a debug grant.
REQ-033 With no owner, the memory outputs SHALL be `mem_we`=0 and `mem_addr` and `mem_wdata` held at 0.
REQ-034 At most one access per cycle SHALL reach the memory.

Reset
REQ-035 While `reset`=0: state=IDLE, `wait_cnt`=0, `dbg_ack`=0, `mem_we`=0, `cpu_stall`=0, and all data/address outputs 0, independent of `clock`.
REQ-036 Reset asserted in DBG_RESP SHALL abandon the transaction with no `dbg_ack` pulse; the requester re-issues it.

Structure
REQ-037 Package `mem_arb_pkg` SHALL hold the state enumeration, ADDR_W/DATA_W defaults and the MAX_WAIT default.
REQ-038 One sub-module, `mem_arb_starve_ctr`, SHALL implement the saturating `wait_cnt`; all other logic is in `mem_arbiter`.

Verification
REQ-039 CPU idle; dbg read addr 0x10, memory holds 0x5A -> `mem_addr`=0x10 in cycle N; `dbg_ack`=1 with `dbg_rdata`=0x5A in N+1; `cpu_stall`=0 throughout.
REQ-040 `cpu_rd` held continuously; dbg write 0x33 to 0x20, MAX_WAIT=4 -> CPU owns the port for 4 cycles; cycle 5 grants debug with `mem_we`=1 and `cpu_stall`=1; ack in cycle 6.
REQ-041 `dbg_halt`=1 with `cpu_wr`=1 -> `cpu_stall`=1 every cycle and `mem_we`=0 until halt drops; a dbg request is granted on its first cycle.
REQ-042 `cpu_rd`=`cpu_wr`=1 at addr 0x08, data 0x77 -> one write of 0x77 to 0x08; `cpu_stall`=0.
REQ-043 Reset pulled low in DBG_RESP -> no `dbg_ack`, state IDLE, `wait_cnt`=0, all outputs 0 before the next clock edge.
REQ-044 Back-to-back dbg reads (`dbg_req` held) with CPU idle -> acks at cycles 2, 4 and 6; in each ack cycle a CPU read issued is serviced without stall.
